fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core, directly upstream of the main decoder.
- Holds the PC and drives the instruction-memory address.
- Captures the fetched word plus PC+4 into the IF/ID register, whose instr_d[31:26] feeds the decoder op input.
- Supports stall, flush (bubble insertion) and branch/jump redirect from later stages.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/if_id_reg.sv | 35 +++
 rtl/fetch_stage.sv | 67 ++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants: reset defaults, opcodes, IF/ID register layout.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction memory port, hazard/redirect controls, IF/ID outputs.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        misalign_err;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, pc_f, instr_d, pcplus4_d, valid_d, misalign_err, fetch_count,
    input  imem_rdata, stall, flush, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, pc_f, instr_d, pcplus4_d, valid_d, misalign_err, fetch_count,
    output imem_rdata, stall, flush, redirect, redirect_pc
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, stall holds, otherwise captures d_i.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t bubble;
  if_id_t ifid_q;
  if_id_t ifid_d;

  assign bubble = '{instr: NOP_WORD, pcplus4: 32'h0, valid: 1'b0};

  // Flush outranks stall so a squashed slot never survives a hold.
  always_comb begin
    ifid_d = d_i;
    if (flush_i)      ifid_d = bubble;
    else if (stall_i) ifid_d = ifid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ifid_q <= bubble;
    else        ifid_q <= ifid_d;
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register with redirect/stall, IF/ID register, misalign flag and fetch counter.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] pc_plus4;
  logic        squash;
  logic        load;
  if_id_t      ifid_in;
  if_id_t      ifid_out;

  assign pc_plus4 = pc_q + 32'd4;
  // A redirect means the word currently in fetch is wrong-path.
  assign squash   = bus.flush | bus.redirect;
  assign load     = !squash && !bus.stall;

  always_comb begin
    pc_d = pc_plus4;
    if (bus.redirect)   pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (bus.stall) pc_d = pc_q;
  end

  assign err_d = err_q | (bus.redirect & (|bus.redirect_pc[1:0]));
  assign cnt_d = cnt_q + 32'(load);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= 32'h0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ifid_in = '{instr: bus.imem_rdata, pcplus4: pc_plus4, valid: 1'b1};

  if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
    .clk     (clk),
    .rst_n   (reset_n),
    .stall_i (bus.stall),
    .flush_i (squash),
    .d_i     (ifid_in),
    .q_o     (ifid_out)
  );

  assign bus.imem_addr    = pc_q;
  assign bus.pc_f         = pc_q;
  assign bus.instr_d      = ifid_out.instr;
  assign bus.pcplus4_d    = ifid_out.pcplus4;
  assign bus.valid_d      = ifid_out.valid;
  assign bus.misalign_err = err_q;
  assign bus.fetch_count  = cnt_q;

endmodule
